joy_db15_tx: RTL and testbench

Emulates the DB15 serial joystick adapter: the device end of the JOY_CLK / JOY_LOAD / JOY_DATA shift-register link that the core's DB15 receiver drives. It snapshots two 12-bit player button words, then shifts them out one bit per JOY_CLK rising edge on JOY_DATA, active-low, like the adapter's parallel-load shift registers. It sits in the bench and loopback builds, between a button source and the DB15 receiver, running on the 48 MHz joystick clock domain.

---
 rtl/joy_db15_tx.sv | 96 +++++++++
 tb/tb_joy_db15_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - DB15 joystick adapter emulator: snapshots two player words and shifts them out on JOY_CLK
module joy_db15_tx #(
  parameter int PW    = 12,
  parameter int FRAME = 2 * PW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [PW-1:0] joy1,
  input  logic [PW-1:0] joy2,
  input  logic          JOY_LOAD,
  input  logic          JOY_CLK,
  output logic          JOY_DATA,
  output logic          frame_done,
  output logic [4:0]    bit_cnt
);

  localparam logic [4:0] CNT_END  = 5'(FRAME);
  localparam logic [4:0] CNT_LAST = 5'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [FRAME-1:0] sr, sr_n;
  logic [4:0]       cnt_n;
  logic             data_n, done_n;

  logic load_s1, load_s2;
  logic jclk_s1, jclk_s2, jclk_h;
  logic load_low, clk_rise;
  logic [FRAME-1:0] snap;

  assign load_low = ~load_s2;
  assign clk_rise = jclk_s2 & ~jclk_h;
  // Inverting at load time makes the serial line active low.
  assign snap     = {~joy2, ~joy1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_s1    <= 1'b1;
      load_s2    <= 1'b1;
      jclk_s1    <= 1'b0;
      jclk_s2    <= 1'b0;
      jclk_h     <= 1'b0;
      state      <= IDLE;
      sr         <= '1;
      bit_cnt    <= CNT_END;
      JOY_DATA   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      load_s1    <= JOY_LOAD;
      load_s2    <= load_s1;
      jclk_s1    <= JOY_CLK;
      jclk_s2    <= jclk_s1;
      jclk_h     <= jclk_s2;
      state      <= state_n;
      sr         <= sr_n;
      bit_cnt    <= cnt_n;
      JOY_DATA   <= data_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = bit_cnt;
    done_n  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (load_low) begin
          state_n = SHIFT;
          sr_n    = snap;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        // A low load wins over a coincident shift edge.
        if (load_low) begin
          sr_n  = snap;
          cnt_n = '0;
        end else if (clk_rise) begin
          sr_n  = {1'b1, sr[FRAME-1:1]};
          cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == CNT_LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Output register is fed from next-state values so it adds no extra latency.
    data_n = (cnt_n < CNT_END) ? sr_n[0] : 1'b1;
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - self-checking bench for joy_db15_tx against a frame-level reference model
module tb_joy_db15_tx;
  localparam int PW    = 12;
  localparam int FRAME = 24;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          JOY_LOAD = 1'b1;
  logic          JOY_CLK  = 1'b0;
  logic [PW-1:0] joy1     = '0;
  logic [PW-1:0] joy2     = '0;
  logic          JOY_DATA;
  logic          frame_done;
  logic [4:0]    bit_cnt;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int fd0;
  logic [FRAME-1:0] exp_frame;

  joy_db15_tx #(.PW(PW), .FRAME(FRAME)) dut (
    .clk(clk), .reset_n(reset_n), .joy1(joy1), .joy2(joy2),
    .JOY_LOAD(JOY_LOAD), .JOY_CLK(JOY_CLK), .JOY_DATA(JOY_DATA),
    .frame_done(frame_done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2 ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_bit(input int idx);
    return (idx < FRAME) ? exp_frame[idx] : 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [PW-1:0] j1, input logic [PW-1:0] j2);
    joy1 = j1;
    joy2 = j2;
    exp_frame = {~j2, ~j1};
    JOY_LOAD = 1'b0;
    cyc(5);
    chk("load_data", 32'(JOY_DATA), 32'(model_bit(0)));
    chk("load_cnt", 32'(bit_cnt), 32'd0);
    cyc(5);
    JOY_LOAD = 1'b1;
    cyc(8);
  endtask

  task automatic shift_run(input int first, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = first + i;
      chk($sformatf("bit%0d", idx), 32'(JOY_DATA), 32'(model_bit(idx)));
      chk($sformatf("cnt%0d", idx), 32'(bit_cnt), (idx < FRAME) ? 32'(idx) : 32'(FRAME));
      JOY_CLK = 1'b1;
      cyc(hi);
      JOY_CLK = 1'b0;
      cyc(lo);
    end
  endtask

  task automatic chk_end(input string tag, input int fd_exp);
    chk({tag, "_fd"}, 32'(fd_cnt - fd0), 32'(fd_exp));
    chk({tag, "_cnt"}, 32'(bit_cnt), 32'(FRAME));
    chk({tag, "_data"}, 32'(JOY_DATA), 32'd1);
  endtask

  initial begin
    // Reset held while pins toggle.
    repeat (6) begin
      JOY_CLK  = ~JOY_CLK;
      JOY_LOAD = ~JOY_LOAD;
      cyc(3);
    end
    chk("rst_data", 32'(JOY_DATA), 32'd1);
    chk("rst_cnt", 32'(bit_cnt), 32'd24);
    chk("rst_fd", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    fd0 = fd_cnt;
    repeat (3) begin
      JOY_CLK = 1'b1; cyc(6);
      JOY_CLK = 1'b0; cyc(6);
    end
    chk_end("idle", 0);

    // Full frame with a known pattern.
    fd0 = fd_cnt;
    do_load(12'h001, 12'h800);
    shift_run(0, 24, 8, 8);
    chk_end("full", 1);

    // Overclocked frame.
    fd0 = fd_cnt;
    do_load(PW'($urandom), PW'($urandom));
    shift_run(0, 30, 8, 8);
    chk_end("over", 1);

    // Mid-frame reload.
    fd0 = fd_cnt;
    do_load(PW'($urandom), PW'($urandom));
    shift_run(0, 7, 8, 8);
    do_load(12'h0F0, PW'($urandom));
    chk("reload_fd", 32'(fd_cnt - fd0), 32'd0);
    shift_run(0, 24, 8, 8);
    chk_end("reload", 1);

    // Snapshot freeze: inputs change after the synced load release.
    fd0 = fd_cnt;
    joy1 = 12'h000;
    joy2 = 12'h000;
    exp_frame = {~joy2, ~joy1};
    JOY_LOAD = 1'b0;
    cyc(10);
    JOY_LOAD = 1'b1;
    cyc(4);
    joy1 = 12'hFFF;
    cyc(4);
    shift_run(0, 24, 8, 8);
    chk_end("freeze", 1);

    // Load low and JOY_CLK rise in the same cycle.
    fd0 = fd_cnt;
    do_load(PW'($urandom), PW'($urandom));
    shift_run(0, 5, 8, 8);
    JOY_LOAD = 1'b0;
    JOY_CLK  = 1'b1;
    cyc(6);
    chk("coin_cnt", 32'(bit_cnt), 32'd0);
    chk("coin_data", 32'(JOY_DATA), 32'(model_bit(0)));
    JOY_CLK = 1'b0;
    cyc(4);
    JOY_LOAD = 1'b1;
    cyc(8);
    shift_run(0, 24, 8, 8);
    chk_end("coin", 1);

    // Randomized frames with random lengths and pulse widths.
    repeat (4) begin
      int n, hi, lo;
      n  = $urandom_range(24, 30);
      hi = $urandom_range(4, 10);
      lo = $urandom_range(4, 10);
      fd0 = fd_cnt;
      do_load(PW'($urandom), PW'($urandom));
      shift_run(0, n, hi, lo);
      chk_end("rand", 1);
    end

    // Asynchronous reset in the middle of a frame.
    fd0 = fd_cnt;
    do_load(PW'($urandom), PW'($urandom));
    shift_run(0, 10, 8, 8);
    chk("mid_cnt", 32'(bit_cnt), 32'd10);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_data", 32'(JOY_DATA), 32'd1);
    chk("arst_cnt", 32'(bit_cnt), 32'd24);
    chk("arst_fd", 32'(frame_done), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    repeat (4) begin
      JOY_CLK = 1'b1; cyc(6);
      JOY_CLK = 1'b0; cyc(6);
    end
    chk_end("post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
